vip_matrix_generate_kxk: RTL and testbench
==========================================

Name: vip_matrix_generate_kxk

Overview:
- Parametrised successor to the fixed 5x5 8-bit window generator. Produces a KSIZE x KSIZE neighbourhood window from a raster pixel stream for the Sobel, Gaussian and Canny stages.
- Line buffers are internal inferred RAMs, with no vendor shift-RAM IP.
- Adds selectable border handling (zero or replicate), a fixed and documented latency, and a line-overflow flag.
- Sits between the camera/greyscale stage and the filter kernels.

Parameters:
- DATA_W, 8, pixel width in bits.
- KSIZE, 5, window size. Legal values are odd, 3..7; other values are an elaboration error.
- MAX_WIDTH, 1024, maximum pixels per line. Sets line-buffer depth and column counter width, clog2(MAX_WIDTH)+1.
- BORDER_MODE, 0, border fill. 0 = out-of-frame taps read 0. 1 = replicate the nearest in-frame row/column.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- pre_frame_vsync  in  1  frame sync; its rising edge starts a frame.
- pre_frame_href  in  1  line valid.
- pre_frame_clken  in  1  pixel strobe; qualified by href.
- pre_img_y  in  DATA_W  pixel.
- matrix_frame_vsync  out  1  vsync delayed by LAT.
- matrix_frame_href  out  1  href delayed by LAT.
- matrix_frame_clken  out  1  clken delayed by LAT.
- matrix_flat  out  KSIZE*KSIZE*DATA_W  window, row-major. Element (i,j) occupies bits [((i*KSIZE+j)+1)*DATA_W-1 -: DATA_W]. i=0 is the oldest row; j=0 is the oldest column.
- line_overflow  out  1  sticky; set when a line exceeds MAX_WIDTH.

Behaviour:
- Reset:
  - All outputs are 0: matrix_flat, the sync outputs, line_overflow.
  - Counters and the delay pipe are cleared.
  - RAM contents are don't-care; border logic must mask them.
- Pixel accept: href & clken in the same cycle. clken without href is ignored.
- Column counter col:
  - Increments per accepted pixel.
  - Clears on the href falling edge.
- Row counter row:
  - Clears on the vsync rising edge.
  - On the href falling edge, increments only if col>0 in that line.
  - Saturates at KSIZE-1.
- Line buffers:
  - KSIZE-1 RAMs, each MAX_WIDTH x DATA_W, chained.
  - On accept: read address col, taps read row r-1..r-(K-1); pixel written to buffer 0 at col; each buffer k's old value written to buffer k+1.
  - Read-during-write returns old data.
- Overflow:
  - An accept with col==MAX_WIDTH sets line_overflow.
  - The pixel is not written and col holds.
  - The window still shifts, using column MAX_WIDTH-1 data.
  - line_overflow clears only on the next vsync rising edge or reset.
- Window:
  - Element (i,KSIZE-1) holds pixel (r-(K-1-i), c).
  - Element (i,j) holds pixel (r-(K-1-i), c-(K-1-j)), where (r,c) is the pixel accepted LAT cycles earlier.
- Border rules:
  - A row index <0 gives 0 (mode 0) or row 0 (mode 1).
  - A column index <0 gives 0 (mode 0) or column 0 of that row (mode 1).
  - Border applies independently per row and per column; the corner uses both rules.
- Latency: LAT = 2 clocks, fixed (RAM read, then window register).
  - Sync outputs are the inputs delayed by exactly 2 clocks.
  - matrix_flat updates only in a cycle where matrix_frame_clken & matrix_frame_href = 1.
- Hold and clear:
  - When delayed clken=0 with href=1, the window holds.
  - When delayed href=0, the window register clears to 0.
- vsync mid-line: row resets, col is unaffected, and no border state carries over from the old frame.
- Async reset mid-frame: everything returns to reset values immediately. The first frame after reset must start with a vsync edge; pixels before it are treated as row 0.

Decomposition:
- Package vip_pkg holds:
  - the BORDER_ZERO/BORDER_REPL constants;
  - a function for the flattened index of (i,j);
  - the LAT constant.
- One sub-module: vip_line_buf_ram, a single-port read-before-write RAM, DATA_W x MAX_WIDTH, instantiated KSIZE-1 times in a generate loop.
- Border muxing and window shift stay in the top module.

Test Plan:
- KSIZE=3, BORDER_MODE=0, MAX_WIDTH=16; 4x4 frame with pixel = 16*r+c, clken always 1.
  - At pixel (2,2) the output window is 00,01,02 / 10,11,12 / 20,21,22 (hex).
  - At pixel (0,0) all elements are 0 except (2,2)=00.
- Same frame with BORDER_MODE=1: at pixel (1,0) the rows read 00,00,00 / 00,00,00 / 10,10,10.
- clken toggling 1/0 within a line:
  - The window advances only on delayed clken.
  - Output equals the continuous-clken case for the same pixels.
  - Sync outputs lag the inputs by exactly 2 clocks.
- 18-pixel line with MAX_WIDTH=16:
  - line_overflow rises 2 cycles after pixel 16 is accepted.
  - It stays high until the next vsync rise.
  - The next line's row data is intact.
- Assert rst_n low at pixel (2,1): all outputs are 0 asynchronously. After release plus a vsync, a fresh 4x4 frame reproduces the window values from the first scenario.
- A line with href high but no clken: row does not increment; the next valid line is still treated as the same row index.

Source files
------------

// File: rtl/vip_pkg.sv
// Shared constants and helpers for the KxK neighbourhood window generator.
package vip_pkg;

    // Border fill selectors for out-of-frame taps.
    localparam int BORDER_ZERO = 0;
    localparam int BORDER_REPL = 1;

    // Fixed pipeline depth: line-buffer read stage, then window register.
    localparam int LAT = 2;

    // Row-major flattened position of window element (i,j).
    function automatic int flat_idx(input int i, input int j, input int ksize);
        return i * ksize + j;
    endfunction

endpackage

// File: rtl/vip_line_buf_ram.sv
// One line of pixel history: single-port RAM, read-before-write.
// The read port is combinational so that the old contents at the current
// column can be forwarded down the buffer chain in the same accept cycle.
module vip_line_buf_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Write the new value at the addressed column; reads see the old value.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/vip_matrix_generate_kxk.sv
// KSIZE x KSIZE sliding window generator over a raster pixel stream.
// Stage 1 registers the current pixel plus the line-buffer taps for the
// same column; stage 2 shifts that column into the window with border fill.
module vip_matrix_generate_kxk
    import vip_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int KSIZE       = 5,
    parameter int MAX_WIDTH   = 1024,
    parameter int BORDER_MODE = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pre_frame_vsync,
    input  logic                          pre_frame_href,
    input  logic                          pre_frame_clken,
    input  logic [DATA_W-1:0]             pre_img_y,
    output logic                          matrix_frame_vsync,
    output logic                          matrix_frame_href,
    output logic                          matrix_frame_clken,
    output logic [KSIZE*KSIZE*DATA_W-1:0] matrix_flat,
    output logic                          line_overflow
);

    localparam int COL_W = $clog2(MAX_WIDTH) + 1;
    localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam int ROW_W = $clog2(KSIZE);
    localparam int NBUF  = KSIZE - 1;

    if ((KSIZE < 3) || (KSIZE > 7) || ((KSIZE % 2) == 0)) begin : g_bad_ksize
        $error("vip_matrix_generate_kxk: KSIZE must be odd and in 3..7");
    end

    // Stage 0: input side
    logic              accept_s, full_s, vs_rise_s, href_fall_s, wr_en_s;
    logic [AW-1:0]     rd_addr_s;
    logic [DATA_W-1:0] tap_s   [NBUF];
    logic [DATA_W-1:0] wdata_s [NBUF];
    logic              vsync_prev_q, href_prev_q;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;

    // Stage 1: one column of pixel history
    logic [DATA_W-1:0] pix_s1_q;
    logic [DATA_W-1:0] tap_s1_q [NBUF];
    logic [COL_W-1:0]  col_s1_q;
    logic [ROW_W-1:0]  row_s1_q;
    logic              ovf_s1_q;
    logic [2:0]        sync_q [LAT];
    logic              href_s1, clken_s1;

    // Stage 2: window
    logic [DATA_W-1:0] src_s     [KSIZE];
    logic [DATA_W-1:0] new_col_s [KSIZE];
    logic [DATA_W-1:0] win_q     [KSIZE][KSIZE];
    logic [DATA_W-1:0] win_d     [KSIZE][KSIZE];
    logic              line_ovf_q, line_ovf_d;

    assign accept_s    = pre_frame_href & pre_frame_clken;
    assign full_s      = (col_q == COL_W'(MAX_WIDTH));
    assign vs_rise_s   = pre_frame_vsync & ~vsync_prev_q;
    assign href_fall_s = href_prev_q & ~pre_frame_href;
    assign wr_en_s     = accept_s & ~full_s;
    // Past the end of the buffer, keep presenting the last stored column.
    assign rd_addr_s   = full_s ? AW'(MAX_WIDTH - 1) : col_q[AW-1:0];

    // Buffer k holds row r-1-k; on accept each buffer passes its old value on.
    for (genvar k = 0; k < NBUF; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign wdata_s[k] = pre_img_y;
        end else begin : g_chain
            assign wdata_s[k] = tap_s[k-1];
        end
        vip_line_buf_ram #(
            .DATA_W (DATA_W),
            .DEPTH  (MAX_WIDTH),
            .AW     (AW)
        ) u_ram (
            .clk     (clk),
            .we_i    (wr_en_s),
            .addr_i  (rd_addr_s),
            .wdata_i (wdata_s[k]),
            .rdata_o (tap_s[k])
        );
    end

    // Column/row position: col per accepted pixel, row per non-empty line.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (href_fall_s) begin
            col_d = '0;
        end else if (wr_en_s) begin
            col_d = col_q + COL_W'(1);
        end else begin
            col_d = col_q;
        end
        if (vs_rise_s) begin
            row_d = '0;
        end else if (href_fall_s && (col_q != '0) && (row_q != ROW_W'(KSIZE - 1))) begin
            row_d = row_q + ROW_W'(1);
        end else begin
            row_d = row_q;
        end
    end

    // Position counters and sync-edge history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
        end else begin
            vsync_prev_q <= pre_frame_vsync;
            href_prev_q  <= pre_frame_href;
            col_q        <= col_d;
            row_q        <= row_d;
        end
    end

    // Stage 1 capture of the pixel, its column's history and its position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_s1_q <= '0;
            col_s1_q <= '0;
            row_s1_q <= '0;
            ovf_s1_q <= 1'b0;
            for (int k = 0; k < NBUF; k++) begin
                tap_s1_q[k] <= '0;
            end
        end else begin
            pix_s1_q <= pre_img_y;
            col_s1_q <= col_q;
            row_s1_q <= row_q;
            ovf_s1_q <= accept_s & full_s;
            for (int k = 0; k < NBUF; k++) begin
                tap_s1_q[k] <= tap_s[k];
            end
        end
    end

    // Delay pipe for {vsync, href, clken}.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                sync_q[s] <= 3'b000;
            end
        end else begin
            sync_q[0] <= {pre_frame_vsync, pre_frame_href, pre_frame_clken};
            for (int s = 1; s < LAT; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign href_s1  = sync_q[LAT-2][1];
    assign clken_s1 = sync_q[LAT-2][0];

    // Build the incoming column; rows above the frame top are zero or row 0.
    always_comb begin
        src_s[0] = pix_s1_q;
        for (int d = 1; d < KSIZE; d++) begin
            src_s[d] = tap_s1_q[d-1];
        end
        new_col_s[KSIZE-1] = pix_s1_q;
        for (int i = 0; i < KSIZE - 1; i++) begin
            if (row_s1_q >= ROW_W'(KSIZE - 1 - i)) begin
                new_col_s[i] = src_s[KSIZE-1-i];
            end else if (BORDER_MODE == BORDER_REPL) begin
                new_col_s[i] = src_s[row_s1_q];
            end else begin
                new_col_s[i] = '0;
            end
        end
    end

    // Window shift; column 0 also fills the left border, idle lines clear it.
    always_comb begin
        win_d = win_q;
        if (!href_s1) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    win_d[i][j] = '0;
                end
            end
        end else if (clken_s1) begin
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE - 1; j++) begin
                    if (col_s1_q == '0) begin
                        win_d[i][j] = (BORDER_MODE == BORDER_REPL) ? new_col_s[i] : '0;
                    end else begin
                        win_d[i][j] = win_q[i][j+1];
                    end
                end
                win_d[i][KSIZE-1] = new_col_s[i];
            end
        end else begin
            win_d = win_q;
        end
    end

    // Sticky overflow, cleared at frame start.
    always_comb begin
        if (vs_rise_s) begin
            line_ovf_d = 1'b0;
        end else if (ovf_s1_q) begin
            line_ovf_d = 1'b1;
        end else begin
            line_ovf_d = line_ovf_q;
        end
    end

    // Window and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_ovf_q <= 1'b0;
            for (int i = 0; i < KSIZE; i++) begin
                for (int j = 0; j < KSIZE; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            line_ovf_q <= line_ovf_d;
            win_q      <= win_d;
        end
    end

    // Flatten the window row-major, oldest row and column at the low bits.
    always_comb begin
        matrix_flat = '0;
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                matrix_flat[(flat_idx(i, j, KSIZE) + 1) * DATA_W - 1 -: DATA_W] = win_q[i][j];
            end
        end
    end

    assign matrix_frame_vsync = sync_q[LAT-1][2];
    assign matrix_frame_href  = sync_q[LAT-1][1];
    assign matrix_frame_clken = sync_q[LAT-1][0];
    assign line_overflow      = line_ovf_q;

endmodule

// File: tb/tb_vip_matrix_generate_kxk.sv
// Directed bench: two 3x3 instances (zero and replicate borders) share one stream.
module tb_vip_matrix_generate_kxk;

    localparam int DW = 8;
    localparam int K  = 3;
    localparam int MW = 16;
    localparam int FW = K * K * DW;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          vs    = 1'b0;
    logic          hr    = 1'b0;
    logic          ce    = 1'b0;
    logic [DW-1:0] y     = '0;

    logic [FW-1:0] mf0, mf1;
    logic          ovs0, ohr0, oce0, ovf0;
    logic          ovs1, ohr1, oce1, ovf1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [FW-1:0] log_mf0   [2048];
    logic [FW-1:0] log_mf1   [2048];
    logic [2:0]    log_sync0 [2048];
    logic [2:0]    log_sync1 [2048];
    logic [2:0]    in_sync   [2048];
    logic          log_ovf0  [2048];
    logic          log_ovf1  [2048];
    int            px_step   [4][18];
    int            gap_step  [4];

    always #5 clk = ~clk;

    vip_matrix_generate_kxk #(.DATA_W(DW), .KSIZE(K), .MAX_WIDTH(MW), .BORDER_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .pre_frame_vsync(vs), .pre_frame_href(hr),
        .pre_frame_clken(ce), .pre_img_y(y), .matrix_frame_vsync(ovs0),
        .matrix_frame_href(ohr0), .matrix_frame_clken(oce0), .matrix_flat(mf0),
        .line_overflow(ovf0));

    vip_matrix_generate_kxk #(.DATA_W(DW), .KSIZE(K), .MAX_WIDTH(MW), .BORDER_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .pre_frame_vsync(vs), .pre_frame_href(hr),
        .pre_frame_clken(ce), .pre_img_y(y), .matrix_frame_vsync(ovs1),
        .matrix_frame_href(ohr1), .matrix_frame_clken(oce1), .matrix_flat(mf1),
        .line_overflow(ovf1));

    // Reference window straight from the pixel-coordinate definition (pixel = 16*r+c).
    function automatic logic [FW-1:0] exp_flat(input int mode, input int r, input int c);
        logic [FW-1:0] f;
        logic [DW-1:0] v;
        int rr, cc;
        f = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                rr = r - (K - 1 - i);
                cc = c - (K - 1 - j);
                if (((rr < 0) || (cc < 0)) && (mode == 0)) begin
                    v = 8'h00;
                end else begin
                    if (rr < 0) rr = 0;
                    if (cc < 0) cc = 0;
                    v = 8'(16 * rr + cc);
                end
                f[(i * K + j) * DW +: DW] = v;
            end
        end
        return f;
    endfunction

    // One clock: drive inputs, pass the edge, log outputs 1 ns later.
    task automatic step(input logic v, input logic h, input logic c, input logic [DW-1:0] d);
        vs = v; hr = h; ce = c; y = d;
        cyc++;
        in_sync[cyc] = {v, h, c};
        @(posedge clk);
        #1;
        log_mf0[cyc]   = mf0;
        log_mf1[cyc]   = mf1;
        log_sync0[cyc] = {ovs0, ohr0, oce0};
        log_sync1[cyc] = {ovs1, ohr1, oce1};
        log_ovf0[cyc]  = ovf0;
        log_ovf1[cyc]  = ovf1;
    endtask

    task automatic send_vsync();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // One line; toggle inserts a clken=0 cycle after each pixel; the gap has clken without href.
    task automatic send_line(input int r, input int w, input bit toggle);
        for (int c = 0; c < w; c++) begin
            px_step[r][c] = cyc + 1;
            step(1'b0, 1'b1, 1'b1, 8'(16 * r + c));
            if (toggle) step(1'b0, 1'b1, 1'b0, 8'hEE);
        end
        gap_step[r] = cyc + 1;
        step(1'b0, 1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic send_frame(input int w, input int h, input bit toggle);
        send_vsync();
        for (int r = 0; r < h; r++) send_line(r, w, toggle);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (mf0 !== '0 || mf1 !== '0) begin
            errors++; $display("FAIL reset_flat: got %h / %h want 0", mf0, mf1);
        end
        checks++;
        if ({ovs0, ohr0, oce0, ovf0, ovs1, ohr1, oce1, ovf1} !== 8'h00) begin
            errors++; $display("FAIL reset_flags: got %b%b%b%b %b%b%b%b want 0",
                ovs0, ohr0, oce0, ovf0, ovs1, ohr1, oce1, ovf1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        checks++;
        if (mf0 !== '0 || ohr0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL reset_idle: got %h href=%b ovf=%b want 0", mf0, ohr0, ovf0);
        end
    endtask

    task automatic test_basic_frame();
        send_frame(4, 4, 1'b0);
        checks++;
        if (log_mf0[px_step[2][2] + 1] !== 72'h222120121110020100) begin
            errors++; $display("FAIL basic_2_2: got %h want %h", log_mf0[px_step[2][2] + 1], 72'h222120121110020100);
        end
        checks++;
        if (log_mf0[px_step[0][0] + 1] !== 72'h0) begin
            errors++; $display("FAIL basic_0_0: got %h want 0", log_mf0[px_step[0][0] + 1]);
        end
        checks++;
        if (log_mf1[px_step[1][0] + 1] !== 72'h101010000000000000) begin
            errors++; $display("FAIL repl_1_0: got %h want %h", log_mf1[px_step[1][0] + 1], 72'h101010000000000000);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int k;
                k = px_step[r][c] + 1;
                checks++;
                if (log_mf0[k] !== exp_flat(0, r, c) || log_sync0[k][1:0] !== 2'b11) begin
                    errors++; $display("FAIL basic_win0 r%0d c%0d: got %h sync %b want %h", r, c, log_mf0[k], log_sync0[k], exp_flat(0, r, c));
                end
                checks++;
                if (log_mf1[k] !== exp_flat(1, r, c)) begin
                    errors++; $display("FAIL basic_win1 r%0d c%0d: got %h want %h", r, c, log_mf1[k], exp_flat(1, r, c));
                end
            end
            checks++;
            if (log_mf0[gap_step[r] + 1] !== '0 || log_mf1[gap_step[r] + 1] !== '0) begin
                errors++; $display("FAIL clear_after_line r%0d: got %h / %h want 0", r, log_mf0[gap_step[r] + 1], log_mf1[gap_step[r] + 1]);
            end
        end
    endtask

    task automatic test_clken_toggle();
        int start;
        start = cyc + 1;
        send_frame(4, 4, 1'b1);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int k;
                k = px_step[r][c] + 1;
                checks++;
                if (log_mf0[k] !== exp_flat(0, r, c) || log_mf1[k] !== exp_flat(1, r, c)) begin
                    errors++; $display("FAIL toggle_win r%0d c%0d: got %h / %h want %h / %h", r, c, log_mf0[k], log_mf1[k], exp_flat(0, r, c), exp_flat(1, r, c));
                end
                checks++;
                if (log_mf0[k + 1] !== exp_flat(0, r, c) || log_sync0[k + 1][1:0] !== 2'b10) begin
                    errors++; $display("FAIL toggle_hold r%0d c%0d: got %h sync %b want %h", r, c, log_mf0[k + 1], log_sync0[k + 1], exp_flat(0, r, c));
                end
            end
        end
        for (int k = start; k < cyc; k++) begin
            checks++;
            if (log_sync0[k + 1] !== in_sync[k] || log_sync1[k + 1] !== in_sync[k]) begin
                errors++; $display("FAIL sync_lag cyc%0d: got %b / %b want %b", k, log_sync0[k + 1], log_sync1[k + 1], in_sync[k]);
            end
        end
    endtask

    task automatic test_no_clken_line();
        send_vsync();
        send_line(0, 4, 1'b0);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        send_line(1, 4, 1'b0);
        send_line(2, 4, 1'b0);
        checks++;
        if (log_mf0[px_step[1][1] + 1] !== 72'h111000010000000000) begin
            errors++; $display("FAIL noclken_zero_1_1: got %h want %h", log_mf0[px_step[1][1] + 1], 72'h111000010000000000);
        end
        checks++;
        if (log_mf1[px_step[1][1] + 1] !== 72'h111010010000010000) begin
            errors++; $display("FAIL noclken_repl_1_1: got %h want %h", log_mf1[px_step[1][1] + 1], 72'h111010010000010000);
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                int k;
                k = px_step[r][c] + 1;
                checks++;
                if (log_mf0[k] !== exp_flat(0, r, c) || log_mf1[k] !== exp_flat(1, r, c)) begin
                    errors++; $display("FAIL noclken_win r%0d c%0d: got %h / %h want %h / %h", r, c, log_mf0[k], log_mf1[k], exp_flat(0, r, c), exp_flat(1, r, c));
                end
            end
        end
    endtask

    task automatic test_overflow();
        int s, vstep;
        send_vsync();
        for (int r = 0; r < 3; r++) send_line(r, 18, 1'b0);
        s = px_step[0][16];
        checks++;
        if (log_ovf0[s - 1] !== 1'b0 || log_ovf0[s] !== 1'b0) begin
            errors++; $display("FAIL ovf_early: got %b%b want 00", log_ovf0[s - 1], log_ovf0[s]);
        end
        checks++;
        if (log_ovf0[s + 1] !== 1'b1 || log_ovf1[s + 1] !== 1'b1) begin
            errors++; $display("FAIL ovf_rise: got %b / %b want 1", log_ovf0[s + 1], log_ovf1[s + 1]);
        end
        for (int k = s + 1; k <= cyc; k++) begin
            checks++;
            if (log_ovf0[k] !== 1'b1) begin
                errors++; $display("FAIL ovf_sticky cyc%0d: got %b want 1", k, log_ovf0[k]);
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < MW; c++) begin
                int k;
                k = px_step[r][c] + 1;
                checks++;
                if (log_mf0[k] !== exp_flat(0, r, c) || log_mf1[k] !== exp_flat(1, r, c)) begin
                    errors++; $display("FAIL ovf_win r%0d c%0d: got %h / %h want %h / %h", r, c, log_mf0[k], log_mf1[k], exp_flat(0, r, c), exp_flat(1, r, c));
                end
            end
        end
        vstep = cyc + 1;
        send_vsync();
        checks++;
        if (log_ovf0[vstep] !== 1'b0 || log_ovf1[vstep] !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got %b / %b want 0", log_ovf0[vstep], log_ovf1[vstep]);
        end
    endtask

    task automatic test_async_reset();
        send_vsync();
        send_line(0, 4, 1'b0);
        send_line(1, 4, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h20);
        step(1'b0, 1'b1, 1'b1, 8'h21);
        checks++;
        if (mf0 !== exp_flat(0, 2, 0) || ohr0 !== 1'b1) begin
            errors++; $display("FAIL pre_reset_win: got %h href=%b want %h", mf0, ohr0, exp_flat(0, 2, 0));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mf0 !== '0 || mf1 !== '0) begin
            errors++; $display("FAIL async_reset_flat: got %h / %h want 0", mf0, mf1);
        end
        checks++;
        if ({ovs0, ohr0, oce0, ovf0, ovs1, ohr1, oce1, ovf1} !== 8'h00) begin
            errors++; $display("FAIL async_reset_flags: got %b%b%b%b %b%b%b%b want 0",
                ovs0, ohr0, oce0, ovf0, ovs1, ohr1, oce1, ovf1);
        end
        hr = 1'b0; ce = 1'b0; y = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(4, 4, 1'b0);
        checks++;
        if (log_mf0[px_step[2][2] + 1] !== 72'h222120121110020100) begin
            errors++; $display("FAIL after_reset_2_2: got %h want %h", log_mf0[px_step[2][2] + 1], 72'h222120121110020100);
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int k;
                k = px_step[r][c] + 1;
                checks++;
                if (log_mf0[k] !== exp_flat(0, r, c) || log_mf1[k] !== exp_flat(1, r, c)) begin
                    errors++; $display("FAIL after_reset_win r%0d c%0d: got %h / %h want %h / %h", r, c, log_mf0[k], log_mf1[k], exp_flat(0, r, c), exp_flat(1, r, c));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_clken_toggle();
        test_no_clken_line();
        test_overflow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
